// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: at an instruction boundary, takes the highest-priority pending
// request, pushes PC and SR, fetches the handler vector and acknowledges the request.
module interrupt_sequencer #(
    parameter int                 NUM_IRQ  = 16,
    parameter logic [15:0]        IVT_BASE = 16'hFFE0,
    parameter logic [NUM_IRQ-1:0] NMI_MASK = NUM_IRQ'(16'h4000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               GIE,
    input  logic               InstrDone,
    input  logic [15:0]        PCin,
    input  logic [15:0]        SPin,
    input  logic [15:0]        SRin,
    input  logic [15:0]        MDBin,
    output logic [15:0]        MAB,
    output logic [15:0]        MDBout,
    output logic               MW,
    output logic               MR,
    output logic               SPF,
    output logic               INTACK,
    output logic [15:0]        ISR,
    output logic [NUM_IRQ-1:0] IRQAck,
    output logic               Busy
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEC_PC  = 3'd1,
        WR_PC   = 3'd2,
        DEC_SR  = 3'd3,
        WR_SR   = 3'd4,
        VEC_RD  = 3'd5,
        VEC_CAP = 3'd6,
        ACK     = 3'd7
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [15:0]        vec_reg, vec_next;

    logic [NUM_IRQ-1:0] enable_mask;
    logic [NUM_IRQ-1:0] pending;
    logic               any_pending;
    logic [IDX_W-1:0]   pri_idx;
    logic [15:0]        vec_addr;

    // Non-maskable lines stay enabled while GIE is clear.
    assign enable_mask = GIE ? {NUM_IRQ{1'b1}} : NMI_MASK;
    assign pending     = IRQ & enable_mask;
    assign any_pending = |pending;

    // Ascending scan: the last set bit seen, i.e. the highest index, wins.
    always_comb begin
        pri_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending[i]) begin
                pri_idx = IDX_W'(i);
            end
        end
    end

    assign vec_addr = IVT_BASE + (16'(idx_reg) << 1);

    // State and captured registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            vec_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            vec_reg   <= vec_next;
        end
    end

    // Next-state logic; the request index is frozen at acceptance.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        vec_next   = vec_reg;
        case (state_reg)
            IDLE: begin
                if (InstrDone && any_pending) begin
                    state_next = DEC_PC;
                    idx_next   = pri_idx;
                end
            end
            DEC_PC:  state_next = WR_PC;
            WR_PC:   state_next = DEC_SR;
            DEC_SR:  state_next = WR_SR;
            WR_SR:   state_next = VEC_RD;
            VEC_RD:  state_next = VEC_CAP;
            VEC_CAP: begin
                state_next = ACK;
                vec_next   = MDBin;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        MAB    = 16'h0000;
        MDBout = 16'h0000;
        MW     = 1'b0;
        MR     = 1'b0;
        SPF    = 1'b0;
        INTACK = 1'b0;
        ISR    = 16'h0000;
        Busy   = (state_reg != IDLE);
        case (state_reg)
            DEC_PC: SPF = 1'b1;
            WR_PC: begin
                MAB    = SPin;
                MDBout = PCin;
                MW     = 1'b1;
            end
            DEC_SR: SPF = 1'b1;
            WR_SR: begin
                MAB    = SPin;
                MDBout = SRin;
                MW     = 1'b1;
            end
            VEC_RD: begin
                MAB = vec_addr;
                MR  = 1'b1;
            end
            ACK: begin
                INTACK = 1'b1;
                ISR    = vec_reg;
            end
            default: ;
        endcase
    end

    // One-hot acknowledge to the serviced peripheral, only during ACK.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_ack
            assign IRQAck[gi] = (state_reg == ACK) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed scenarios plus randomized entries
// compared cycle by cycle against a table-driven model of the entry protocol.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] IRQ = '0;
    logic        GIE = 1'b0;
    logic        InstrDone = 1'b0;
    logic [15:0] PCin = '0;
    logic [15:0] SPin = '0;
    logic [15:0] SRin = '0;
    logic [15:0] MDBin = '0;
    logic [15:0] MAB, MDBout, ISR, IRQAck;
    logic        MW, MR, SPF, INTACK, Busy;

    int checks = 0;
    int failures = 0;

    logic [15:0] ivt [0:15];
    logic [68:0] obs_arr [0:8];

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .IRQ(IRQ), .GIE(GIE), .InstrDone(InstrDone),
        .PCin(PCin), .SPin(SPin), .SRin(SRin), .MDBin(MDBin),
        .MAB(MAB), .MDBout(MDBout), .MW(MW), .MR(MR), .SPF(SPF),
        .INTACK(INTACK), .ISR(ISR), .IRQAck(IRQAck), .Busy(Busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [68:0] pack_outputs();
        return {Busy, SPF, MW, MR, INTACK, MAB, MDBout, ISR, IRQAck};
    endfunction

    function automatic logic [15:0] lookup(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'hFFE0;
        if (off < 16'd32 && !off[0]) return ivt[off[4:1]];
        return 16'hBAD0;
    endfunction

    function automatic int hi_idx(input logic [15:0] p);
        int r = -1;
        for (int i = 0; i < 16; i++) if (p[i]) r = i;
        return r;
    endfunction

    // Protocol table: cycle k after the accepting boundary (k=0 is the boundary itself).
    function automatic logic [68:0] exp_obs(input int k, input int idx, input logic [15:0] sp0,
                                            input logic [15:0] pc, input logic [15:0] sr);
        logic b, spf, mw, mr, ack;
        logic [15:0] mab, mdb, isr, irqack;
        {b, spf, mw, mr, ack} = 5'b0;
        mab = 0; mdb = 0; isr = 0; irqack = 0;
        if (idx >= 0) begin
            b = (k >= 1 && k <= 7);
            case (k)
                1: spf = 1;
                2: begin mw = 1; mab = sp0 - 16'd2; mdb = pc; end
                3: spf = 1;
                4: begin mw = 1; mab = sp0 - 16'd4; mdb = sr; end
                5: begin mr = 1; mab = 16'hFFE0 + 16'(2 * idx); end
                7: begin ack = 1; isr = ivt[idx]; irqack = 16'(1) << idx; end
                default: ;
            endcase
        end
        return {b, spf, mw, mr, ack, mab, mdb, isr, irqack};
    endfunction

    // One clock: sample at the falling edge, then act as register file and memory.
    task automatic step(output logic [68:0] o);
        logic s_spf, s_mr;
        logic [15:0] s_mab;
        @(negedge clk);
        o = pack_outputs();
        s_spf = SPF; s_mr = MR; s_mab = MAB;
        @(posedge clk);
        #1;
        if (s_spf) SPin = SPin - 16'd2;
        MDBin = s_mr ? lookup(s_mab) : 16'($urandom);
    endtask

    task automatic run_entry(input logic [15:0] irq, input logic gie, input logic [15:0] pc,
                             input logic [15:0] sr, input logic [15:0] sp,
                             input int drop_at, input logic [15:0] irq_drop);
        SPin = sp; PCin = pc; SRin = sr; IRQ = irq; GIE = gie; InstrDone = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            if (k == drop_at) IRQ = irq_drop;
            step(obs_arr[k]);
            if (k == 0) InstrDone = 1'b0;
        end
    endtask

    task automatic check_trace(input string name, input int idx, input logic [15:0] sp0,
                               input logic [15:0] pc, input logic [15:0] sr);
        logic [68:0] e;
        for (int k = 0; k <= 8; k++) begin
            e = exp_obs(k, idx, sp0, pc, sr);
            checks++;
            if (obs_arr[k] !== e) begin
                failures++;
                $display("FAIL %s c%0d: got %h want %h", name, k, obs_arr[k], e);
            end
        end
        $display("txn %s idx=%0d done", name, idx);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (pack_outputs() !== 69'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", pack_outputs());
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("txn reset done");
    endtask

    task automatic test_basic();
        run_entry(16'h0020, 1'b1, 16'hC010, 16'h0008, 16'h0400, -1, 16'h0);
        check_trace("basic", 5, 16'h0400, 16'hC010, 16'h0008);
    endtask

    task automatic test_no_entry();
        logic [68:0] o;
        IRQ = 16'h0020; GIE = 1'b0; InstrDone = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(o);
            checks++;
            if (o[68:64] !== 5'b0) begin
                failures++;
                $display("FAIL masked_no_entry c%0d: got flags %b want 00000", k, o[68:64]);
            end
        end
        IRQ = 16'h0081; GIE = 1'b1; InstrDone = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(o);
            checks++;
            if (o[68] !== 1'b0) begin
                failures++;
                $display("FAIL no_boundary c%0d: got Busy %b want 0", k, o[68]);
            end
        end
        IRQ = 16'h0;
        $display("txn no_entry done");
    endtask

    task automatic test_nmi();
        run_entry(16'h4000, 1'b0, 16'h8002, 16'h0000, 16'h0300, -1, 16'h0);
        check_trace("nmi", 14, 16'h0300, 16'h8002, 16'h0000);
    endtask

    task automatic test_priority();
        run_entry(16'h0120, 1'b1, 16'hD000, 16'h0009, 16'h0500, -1, 16'h0);
        check_trace("tie_high", 8, 16'h0500, 16'hD000, 16'h0009);
        run_entry(16'h0020, 1'b1, 16'hD002, 16'h0008, 16'h04FC, -1, 16'h0);
        check_trace("tie_low_next", 5, 16'h04FC, 16'hD002, 16'h0008);
    endtask

    task automatic test_drop();
        run_entry(16'h0020, 1'b1, 16'hC010, 16'h0008, 16'h0400, 2, 16'h0);
        check_trace("dropped_req", 5, 16'h0400, 16'hC010, 16'h0008);
    endtask

    task automatic test_reset_mid();
        logic [68:0] o;
        SPin = 16'h0600; PCin = 16'hE000; SRin = 16'h000C; IRQ = 16'h0004; GIE = 1'b1;
        InstrDone = 1'b1;
        step(o);
        InstrDone = 1'b0;
        for (int k = 1; k <= 3; k++) step(o);
        #2;
        checks++;
        if (MW !== 1'b1 || MDBout !== 16'h000C) begin
            failures++;
            $display("FAIL mid_reset_pre: got MW %b MDBout %h want 1 000c", MW, MDBout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pack_outputs() !== 69'd0) begin
            failures++;
            $display("FAIL mid_reset_async: got %h want 0", pack_outputs());
        end
        for (int k = 0; k < 4; k++) begin
            step(o);
            checks++;
            if (o !== 69'd0) begin
                failures++;
                $display("FAIL mid_reset_hold c%0d: got %h want 0", k, o);
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(o);
            checks++;
            if (o !== 69'd0) begin
                failures++;
                $display("FAIL post_reset_idle c%0d: got %h want 0", k, o);
            end
        end
        run_entry(16'h0004, 1'b1, 16'hE000, 16'h000C, 16'h0600, -1, 16'h0);
        check_trace("reentry_after_reset", 2, 16'h0600, 16'hE000, 16'h000C);
    endtask

    task automatic test_random();
        logic [15:0] irq, pc, sr, sp, pend;
        logic gie;
        int idx;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++) ivt[i] = 16'($urandom);
            irq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            gie = 1'($urandom);
            pc  = 16'($urandom);
            sr  = 16'($urandom);
            sp  = 16'($urandom_range(16, 65535)) & 16'hFFFE;
            pend = gie ? irq : (irq & 16'h4000);
            idx = hi_idx(pend);
            run_entry(irq, gie, pc, sr, sp, (n % 3 == 0) ? 3 : -1, 16'($urandom));
            check_trace("random", idx, sp, pc, sr);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ivt[i] = 16'($urandom);
        ivt[5]  = 16'hC200;
        ivt[14] = 16'hF00E;
        ivt[8]  = 16'hC800;
        ivt[2]  = 16'hC020;
        test_reset();
        test_basic();
        test_no_entry();
        test_nmi();
        test_priority();
        test_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
